pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the IF -> IF_ID -> ID -> ID_EXE -> EXE -> EXE_MEM -> MEM -> WB core.

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/hazard_scoreboard.sv | 78 +++++++
 rtl/pipe_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline sequencer and the blocks around it.
//   RFW_DEFAULT : register-address width used by the RF, ID and hazard logic
//   REG_ZERO    : hard-wired zero register, never a hazard source
//   S_*         : run-control state encodings, wrapped by state_e
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

   localparam int RFW_DEFAULT = 5;
   localparam int REG_ZERO    = 0;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = S_IDLE,
      ST_RUN   = S_RUN,
      ST_DRAIN = S_DRAIN,
      ST_DONE  = S_DONE
   } state_e;

endpackage : pipe_ctrl_pkg

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Destination-register shift register for the instructions between ID and WB.
// Entry 0 is the instruction now in EXE; each cycle entries move one stage
// towards WB and the oldest falls off. The ID sources are compared against
// every valid entry.
// Ports:
//   clk, reset        : core clock, synchronous active-high reset
//   clear             : drop every entry (run start)
//   push_v, push_rd   : entry loaded into slot 0 this cycle
//   rs1/rs2, *_used   : sources of the instruction in ID
//   hazard            : some read source matches a pending destination
//   empty             : no valid entries
// -----------------------------------------------------------------------------
module hazard_scoreboard
   import pipe_ctrl_pkg::*;
#(
   parameter int RFW       = RFW_DEFAULT,
   parameter int HAZ_DEPTH = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           clear,
   input  logic           push_v,
   input  logic [RFW-1:0] push_rd,
   input  logic [RFW-1:0] rs1,
   input  logic           rs1_used,
   input  logic [RFW-1:0] rs2,
   input  logic           rs2_used,
   output logic           hazard,
   output logic           empty
);

   logic [HAZ_DEPTH-1:0]          vld_pipe_q, vld_pipe_d;
   logic [HAZ_DEPTH-1:0][RFW-1:0] rd_pipe_q,  rd_pipe_d;
   logic [HAZ_DEPTH-1:0]          match;
   logic                          rs1_live, rs2_live;

   always_comb begin
      vld_pipe_d = '0;
      rd_pipe_d  = '0;
      if (!clear) begin
         vld_pipe_d[0] = push_v;
         rd_pipe_d[0]  = push_rd;
         for (int k = 1; k < HAZ_DEPTH; k++) begin
            vld_pipe_d[k] = vld_pipe_q[k-1];
            rd_pipe_d[k]  = rd_pipe_q[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe_q <= '0;
         rd_pipe_q  <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         rd_pipe_q  <= rd_pipe_d;
      end
   end

   // Reads of the zero register never wait on anything.
   assign rs1_live = rs1_used & (rs1 != RFW'(REG_ZERO));
   assign rs2_live = rs2_used & (rs2 != RFW'(REG_ZERO));

   genvar g;
   generate
      for (g = 0; g < HAZ_DEPTH; g++) begin : g_cmp
         assign match[g] = vld_pipe_q[g] &
                           ((rs1_live & (rs1 == rd_pipe_q[g])) |
                            (rs2_live & (rs2 == rd_pipe_q[g])));
      end
   endgenerate

   assign hazard = |match;
   assign empty  = ~|vld_pipe_q;

endmodule : hazard_scoreboard

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Run control and hazard sequencing for the 5-stage core (no forwarding,
// write-through RF). Stalls ID on RAW hazards against EXE/MEM destinations,
// flushes on an EXE branch redirect, and drains the pipe after HALT.
// Ports:
//   clk, reset               : core clock, synchronous active-high reset
//   start                    : level, begins a run from IDLE or DONE
//   id_*                     : decoded fields of the instruction in ID
//   exe_redirect             : taken branch in EXE
//   pc_en, pc_clr            : PC advance / one-cycle clear at run start
//   if_id_en, if_id_flush    : IF_ID load / load-bubble
//   id_exe_bubble            : ID_EXE takes a bubble
//   busy, done               : RUN|DRAIN / DONE status
//   stall_cnt                : saturating hazard-stall count for this run
// pc_clr is high in the first RUN cycle together with pc_en; the PC register
// gives the clear priority.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int RFW       = RFW_DEFAULT,
   parameter int HAZ_DEPTH = 2,
   parameter int CNTW      = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [RFW-1:0]  id_rs1,
   input  logic [RFW-1:0]  id_rs2,
   input  logic            id_rs1_used,
   input  logic            id_rs2_used,
   input  logic [RFW-1:0]  id_rd,
   input  logic            id_wr_en,
   input  logic            id_valid,
   input  logic            id_halt,
   input  logic            exe_redirect,
   output logic            pc_en,
   output logic            pc_clr,
   output logic            if_id_en,
   output logic            if_id_flush,
   output logic            id_exe_bubble,
   output logic            busy,
   output logic            done,
   output logic [CNTW-1:0] stall_cnt
);

   localparam int DCW = $clog2(HAZ_DEPTH + 1);

   state_e           state_q, state_d;
   logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
   logic             pc_clr_q, pc_clr_d;
   logic [CNTW-1:0]  stall_cnt_q, stall_cnt_d;

   logic             sb_clear, sb_push_v, sb_hazard, sb_empty, hazard;

   hazard_scoreboard #(
      .RFW       (RFW),
      .HAZ_DEPTH (HAZ_DEPTH)
   ) u_sb (
      .clk      (clk),
      .reset    (reset),
      .clear    (sb_clear),
      .push_v   (sb_push_v),
      .push_rd  (id_rd),
      .rs1      (id_rs1),
      .rs1_used (id_rs1_used),
      .rs2      (id_rs2),
      .rs2_used (id_rs2_used),
      .hazard   (sb_hazard),
      .empty    (sb_empty)
   );

   assign hazard = id_valid & sb_hazard;

   always_comb begin
      state_d       = state_q;
      drain_cnt_d   = drain_cnt_q;
      pc_clr_d      = 1'b0;
      stall_cnt_d   = stall_cnt_q;
      sb_clear      = 1'b0;
      sb_push_v     = 1'b0;
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b0;
      id_exe_bubble = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            done = (state_q == ST_DONE);
            if (start) begin
               state_d     = ST_RUN;
               pc_clr_d    = 1'b1;
               stall_cnt_d = '0;
               sb_clear    = 1'b1;
            end
         end

         ST_RUN: begin
            busy = 1'b1;
            if (exe_redirect) begin
               // Squash ID: nothing enters the scoreboard, HALT is dropped.
               pc_en         = 1'b1;
               if_id_en      = 1'b1;
               if_id_flush   = 1'b1;
               id_exe_bubble = 1'b1;
            end else if (hazard) begin
               id_exe_bubble = 1'b1;
               if (!(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
            end else begin
               // ID issues into EXE.
               sb_push_v = id_valid & id_wr_en & (id_rd != RFW'(REG_ZERO));
               if (id_valid && id_halt) begin
                  if_id_flush = 1'b1;
                  state_d     = ST_DRAIN;
                  drain_cnt_d = DCW'(HAZ_DEPTH);
               end else begin
                  pc_en    = 1'b1;
                  if_id_en = 1'b1;
               end
            end
         end

         ST_DRAIN: begin
            busy          = 1'b1;
            if_id_flush   = 1'b1;
            id_exe_bubble = 1'b1;
            if (drain_cnt_q != '0) drain_cnt_d = drain_cnt_q - 1'b1;
            // Finish once the count has run out and nothing is still in flight.
            if ((drain_cnt_d == '0) && sb_empty) state_d = ST_DONE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         drain_cnt_q <= '0;
         pc_clr_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         pc_clr_q    <= pc_clr_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign pc_clr    = pc_clr_q;
   assign stall_cnt = stall_cnt_q;

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. CNTW is shrunk to 4 so saturation of
// the stall counter is reachable in a few dozen cycles.
module tb_pipe_hazard_ctrl;

   localparam int RFW  = 5;
   localparam int CNTW = 4;

   // {pc_en, pc_clr, if_id_en, if_id_flush, id_exe_bubble, busy, done}
   localparam logic [6:0] O_IDLE  = 7'b0000000;
   localparam logic [6:0] O_FIRST = 7'b1110010;
   localparam logic [6:0] O_NORM  = 7'b1010010;
   localparam logic [6:0] O_HAZ   = 7'b0000110;
   localparam logic [6:0] O_REDIR = 7'b1011110;
   localparam logic [6:0] O_HALT  = 7'b0001010;
   localparam logic [6:0] O_DRAIN = 7'b0001110;
   localparam logic [6:0] O_DONE  = 7'b0000001;

   logic clk, reset, start;
   logic [RFW-1:0] id_rs1, id_rs2, id_rd;
   logic id_rs1_used, id_rs2_used, id_wr_en, id_valid, id_halt, exe_redirect;
   logic pc_en, pc_clr, if_id_en, if_id_flush, id_exe_bubble, busy, done;
   logic [CNTW-1:0] stall_cnt;
   logic [6:0] outs;

   int n_cmp = 0;
   int n_err = 0;

   assign outs = {pc_en, pc_clr, if_id_en, if_id_flush, id_exe_bubble, busy, done};

   pipe_hazard_ctrl #(.RFW(RFW), .HAZ_DEPTH(2), .CNTW(CNTW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_wr_en(id_wr_en), .id_valid(id_valid), .id_halt(id_halt),
      .exe_redirect(exe_redirect),
      .pc_en(pc_en), .pc_clr(pc_clr), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
      .id_exe_bubble(id_exe_bubble), .busy(busy), .done(done), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no end of run, expected $finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check this cycle's combinational outputs, then advance one clock.
   task automatic cyc(input string tag, input logic [6:0] exp);
      #1;
      chk(tag, 32'(outs), 32'(exp));
      tick();
   endtask

   task automatic set_id(input logic v, input int r1, input logic u1, input int r2,
                         input logic u2, input int rd, input logic wr, input logic h);
      id_valid    = v;
      id_rs1      = RFW'(r1);
      id_rs1_used = u1;
      id_rs2      = RFW'(r2);
      id_rs2_used = u2;
      id_rd       = RFW'(rd);
      id_wr_en    = wr;
      id_halt     = h;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; exe_redirect = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);

      // 1: reset, then start
      tick();
      chk("rst1_outs", 32'(outs), 32'(O_IDLE));
      tick();
      chk("rst2_outs", 32'(outs), 32'(O_IDLE));
      chk("rst2_cnt", 32'(stall_cnt), 0);
      reset = 1'b0; start = 1'b1;
      cyc("idle_start", O_IDLE);
      start = 1'b0;
      cyc("run_first", O_FIRST);
      cyc("run_norm", O_NORM);

      // 2: back-to-back RAW on r3 -> two stalls
      set_id(1, 0, 0, 0, 0, 3, 1, 0);
      cyc("t2_prod", O_NORM);
      set_id(1, 3, 1, 0, 0, 0, 0, 0);
      cyc("t2_stall1", O_HAZ);
      chk("t2_cnt1", 32'(stall_cnt), 1);
      cyc("t2_stall2", O_HAZ);
      chk("t2_cnt2", 32'(stall_cnt), 2);
      cyc("t2_issue", O_NORM);
      chk("t2_cnt_final", 32'(stall_cnt), 2);

      // 3: r0 never stalls; one-instruction gap -> one stall
      set_id(1, 0, 0, 0, 0, 0, 1, 0);
      cyc("t3_r0_prod", O_NORM);
      set_id(1, 0, 1, 0, 1, 0, 0, 0);
      cyc("t3_r0_cons", O_NORM);
      set_id(1, 0, 0, 0, 0, 7, 1, 0);
      cyc("t3_gap_prod", O_NORM);
      set_id(1, 7, 0, 0, 0, 0, 0, 0);
      cyc("t3_unused_src", O_NORM);
      set_id(1, 0, 0, 7, 1, 0, 0, 0);
      cyc("t3_gap_stall", O_HAZ);
      cyc("t3_gap_issue", O_NORM);
      chk("t3_cnt", 32'(stall_cnt), 3);

      // 4: redirect beats hazard and halt
      set_id(1, 0, 0, 0, 0, 9, 1, 0);
      cyc("t4_prod", O_NORM);
      set_id(1, 9, 1, 0, 0, 0, 0, 1);
      exe_redirect = 1'b1;
      cyc("t4_redirect", O_REDIR);
      chk("t4_cnt", 32'(stall_cnt), 3);
      exe_redirect = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      cyc("t4_still_run", O_NORM);

      // 5: halt with r5 in flight -> 2 drain cycles, DONE, restart
      set_id(1, 0, 0, 0, 0, 5, 1, 0);
      cyc("t5_prod", O_NORM);
      set_id(1, 0, 0, 0, 0, 0, 0, 1);
      cyc("t5_halt", O_HALT);
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      cyc("t5_drain1", O_DRAIN);
      cyc("t5_drain2", O_DRAIN);
      cyc("t5_done", O_DONE);
      cyc("t5_done_hold", O_DONE);
      chk("t5_cnt_kept", 32'(stall_cnt), 3);
      start = 1'b1;
      cyc("t5_restart_req", O_DONE);
      start = 1'b0;
      chk("t5_cnt_clr", 32'(stall_cnt), 0);
      cyc("t5_pc_clr", O_FIRST);
      cyc("t5_run", O_NORM);

      // 6a: reset mid-stall
      set_id(1, 0, 0, 0, 0, 4, 1, 0);
      cyc("t6_prod", O_NORM);
      set_id(1, 4, 1, 0, 0, 0, 0, 0);
      cyc("t6_stall", O_HAZ);
      chk("t6_stall_cnt", 32'(stall_cnt), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("t6_rst_stall_outs", 32'(outs), 32'(O_IDLE));
      chk("t6_rst_stall_cnt", 32'(stall_cnt), 0);
      start = 1'b1;
      cyc("t6_start", O_IDLE);
      start = 1'b0;
      cyc("t6_sb_cleared", O_FIRST);

      // 6b: reset mid-drain
      set_id(1, 0, 0, 0, 0, 0, 0, 1);
      cyc("t6_halt", O_HALT);
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      cyc("t6_drain", O_DRAIN);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("t6_rst_drain_outs", 32'(outs), 32'(O_IDLE));
      cyc("t6_idle_hold", O_IDLE);

      // 6c: stall counter saturates at 4'hF
      start = 1'b1;
      cyc("t6_sat_start", O_IDLE);
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         set_id(1, 0, 0, 0, 0, 2, 1, 0);
         tick();
         set_id(1, 2, 1, 0, 0, 0, 0, 0);
         cyc("sat_stall_a", O_HAZ);
         cyc("sat_stall_b", O_HAZ);
         if (i == 6) chk("sat_cnt_14", 32'(stall_cnt), 14);
         if (i == 7) chk("sat_cnt_15", 32'(stall_cnt), 15);
      end
      chk("sat_cnt_hold", 32'(stall_cnt), 15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_pipe_hazard_ctrl
